trackball_quad_encoder: RTL and testbench

//   Transmit end of the trackball interface. Converts relative pointer deltas
//   (MiSTer mouse/analog, one strobe per report) into the quadrature pairs
//   tb1HC/tb1HD (horizontal) and tb1VC/tb1VD (vertical) that the LETA

---
 rtl/cc_trackball_pkg.sv | 50 +++++
 rtl/quad_axis.sv | 74 +++++++
 rtl/trackball_quad_encoder.sv | 80 ++++++++
 tb/tb_trackball_quad_encoder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cc_trackball_pkg.sv
// Shared definitions for the trackball quadrature encoder.
// Covers the phase encoding, phase stepping and saturating accumulator arithmetic.
package cc_trackball_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  // One step in the positive direction: C leads D
  function automatic phase_t ph_next(input phase_t ph);
    case (ph)
      PH_00:   ph_next = PH_10;
      PH_10:   ph_next = PH_11;
      PH_11:   ph_next = PH_01;
      PH_01:   ph_next = PH_00;
      default: ph_next = PH_00;
    endcase
  endfunction

  function automatic phase_t ph_prev(input phase_t ph);
    case (ph)
      PH_00:   ph_prev = PH_01;
      PH_01:   ph_prev = PH_11;
      PH_11:   ph_prev = PH_10;
      PH_10:   ph_prev = PH_00;
      default: ph_prev = PH_00;
    endcase
  endfunction

  // Symmetric clamp to +/-(2^(acc_w-1)-1); excess counts are dropped
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 acc_w);
    logic signed [31:0] lim;
    logic signed [31:0] sum;
    lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    sum = a + b;
    if (sum > lim) begin
      sat_add = lim;
    end else if (sum < -lim) begin
      sat_add = -lim;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/quad_axis.sv
// One trackball axis: pending-count accumulator feeding a quadrature phase
// register that moves one state per shared tick.
module quad_axis
  import cc_trackball_pkg::*;
#(
  parameter int ACC_W       = 10,
  parameter int SCALE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       stb,
  input  logic [8:0] delta,
  input  logic       inv,
  input  logic       enable,
  output logic       ph_c,
  output logic       ph_d,
  output logic       nonzero
);

  logic [ACC_W-1:0]   acc_r;
  phase_t             phase_r;
  logic signed [31:0] delta_s;
  logic signed [31:0] d_s;
  logic signed [31:0] acc_s;
  logic signed [31:0] dir_s;
  logic signed [31:0] add_s;
  logic signed [31:0] sum_s;

  // Scale the delta, then combine it with the step taken from the pre-update accumulator
  always_comb begin
    delta_s = {{23{delta[8]}}, delta};
    if (inv) begin
      d_s = (-delta_s) >>> SCALE_SHIFT;
    end else begin
      d_s = delta_s >>> SCALE_SHIFT;
    end
    acc_s = {{(32 - ACC_W){acc_r[ACC_W-1]}}, acc_r};
    if (acc_s == 32'sd0) begin
      dir_s = 32'sd0;
    end else if (acc_s < 32'sd0) begin
      dir_s = -32'sd1;
    end else begin
      dir_s = 32'sd1;
    end
    add_s = (stb ? d_s : 32'sd0) - (tick ? dir_s : 32'sd0);
    sum_s = sat_add(acc_s, add_s, ACC_W);
  end

  // Accumulator and phase state; disable clears pending counts but keeps the phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r   <= '0;
      phase_r <= PH_00;
    end else if (!enable) begin
      acc_r   <= '0;
      phase_r <= phase_r;
    end else begin
      acc_r <= sum_s[ACC_W-1:0];
      if (tick && (dir_s > 32'sd0)) begin
        phase_r <= ph_next(phase_r);
      end else if (tick && (dir_s < 32'sd0)) begin
        phase_r <= ph_prev(phase_r);
      end else begin
        phase_r <= phase_r;
      end
    end
  end

  assign ph_c    = phase_r[1];
  assign ph_d    = phase_r[0];
  assign nonzero = (acc_r != '0);

endmodule

// File: rtl/trackball_quad_encoder.sv
// Converts relative pointer deltas into rate-limited quadrature pairs for
// the horizontal and vertical trackball axes.
module trackball_quad_encoder
  import cc_trackball_pkg::*;
#(
  parameter int STEP_DIV    = 1000,
  parameter int ACC_W       = 10,
  parameter int SCALE_SHIFT = 0,
  parameter int INV_X       = 0,
  parameter int INV_Y       = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       mouse_stb,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  output logic       tb1HC,
  output logic       tb1HD,
  output logic       tb1VC,
  output logic       tb1VD,
  output logic       busy
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

  logic [DIV_W-1:0] div_r;
  logic             tick_s;
  logic             h_nz_s;
  logic             v_nz_s;

  assign tick_s = (div_r == DIV_LAST);

  // Free-running step-slot divider shared by both axes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r <= '0;
    end else if (tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  quad_axis #(
    .ACC_W       (ACC_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_axis_h (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_s),
    .stb     (mouse_stb),
    .delta   (mouse_dx),
    .inv     (INV_X != 0),
    .enable  (enable),
    .ph_c    (tb1HC),
    .ph_d    (tb1HD),
    .nonzero (h_nz_s)
  );

  quad_axis #(
    .ACC_W       (ACC_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_axis_v (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick_s),
    .stb     (mouse_stb),
    .delta   (mouse_dy),
    .inv     (INV_Y != 0),
    .enable  (enable),
    .ph_c    (tb1VC),
    .ph_d    (tb1VD),
    .nonzero (v_nz_s)
  );

  assign busy = h_nz_s | v_nz_s;

endmodule

// File: tb/tb_trackball_quad_encoder.sv
// Directed and randomized checks of trackball_quad_encoder against a
// position-counting reference model of a physical trackball.
module tb_trackball_quad_encoder;

  localparam int SD  = 4;
  localparam int LIM = 511;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       mouse_stb = 1'b0;
  logic [8:0] mouse_dx = 9'd0;
  logic [8:0] mouse_dy = 9'd0;
  logic       tb1HC, tb1HD, tb1VC, tb1VD, busy;

  trackball_quad_encoder #(
    .STEP_DIV(SD), .ACC_W(10), .SCALE_SHIFT(0), .INV_X(0), .INV_Y(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mouse_stb(mouse_stb),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy),
    .tb1HC(tb1HC), .tb1HD(tb1HD), .tb1VC(tb1VC), .tb1VD(tb1VD), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  // Reference model: pending counts and absolute wheel position per axis
  int m_div = 0;
  int m_accx = 0, m_accy = 0;
  int m_posx = 0, m_posy = 0;
  logic [1:0] h_log[$];
  logic [1:0] v_log[$];
  int h_cyc[$];
  logic [1:0] h_prev = 2'b00, v_prev = 2'b00;

  function automatic logic [1:0] ph_of(input int pos);
    int m;
    m = ((pos % 4) + 4) % 4;
    case (m)
      0: ph_of = 2'b00;
      1: ph_of = 2'b10;
      2: ph_of = 2'b11;
      default: ph_of = 2'b01;
    endcase
  endfunction

  function automatic int sgn(input int a);
    sgn = (a > 0) ? 1 : ((a < 0) ? -1 : 0);
  endfunction

  function automatic int clampv(input int a);
    clampv = (a > LIM) ? LIM : ((a < -LIM) ? -LIM : a);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic axis_model(input int acc_i, input int pos_i, input int d, input bit tk,
                            output int acc_o, output int pos_o);
    int s;
    acc_o = acc_i;
    pos_o = pos_i;
    if (!enable) begin
      acc_o = 0;
    end else begin
      s = sgn(acc_i);
      if (tk) pos_o = pos_i + s;
      acc_o = clampv(acc_i + (mouse_stb ? d : 0) - (tk ? s : 0));
    end
  endtask

  task automatic model_reset();
    m_div = 0; m_accx = 0; m_accy = 0; m_posx = 0; m_posy = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic cycle();
    bit tk;
    int ax, px, ay, py;
    logic [1:0] oh, ov;
    @(posedge clk);
    if (reset_n) begin
      tk = (m_div == SD - 1);
      m_div = tk ? 0 : m_div + 1;
      axis_model(m_accx, m_posx, int'($signed(mouse_dx)), tk, ax, px);
      axis_model(m_accy, m_posy, int'($signed(mouse_dy)), tk, ay, py);
      m_accx = ax; m_posx = px; m_accy = ay; m_posy = py;
    end
    cyc++;
    #1;
    chk("outputs", int'({tb1HC, tb1HD, tb1VC, tb1VD, busy}),
        int'({ph_of(m_posx), ph_of(m_posy), (m_accx != 0) || (m_accy != 0)}));
    oh = {tb1HC, tb1HD};
    ov = {tb1VC, tb1VD};
    if (oh !== h_prev) begin h_log.push_back(oh); h_cyc.push_back(cyc); end
    if (ov !== v_prev) v_log.push_back(ov);
    h_prev = oh;
    v_prev = ov;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic strobe(input logic [8:0] dx, input logic [8:0] dy);
    mouse_dx = dx; mouse_dy = dy; mouse_stb = 1'b1;
    cycle();
    mouse_stb = 1'b0; mouse_dx = 9'd0; mouse_dy = 9'd0;
  endtask

  task automatic clear_logs();
    h_log.delete(); v_log.delete(); h_cyc.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((m_accx != 0) || (m_accy != 0)) && (n < 2500)) begin cycle(); n++; end
    chk("drain_bound", int'(n < 2500), 1);
  endtask

  initial begin
    int p0, n;
    // 1. Reset and idle
    enable = 1'b1;
    run(3);
    chk("reset_state", int'({tb1HC, tb1HD, tb1VC, tb1VD, busy}), 0);
    reset_n = 1'b1;
    clear_logs();
    run(40);
    chk("idle_toggles", h_log.size() + v_log.size(), 0);

    // 2. Positive X: three steps, one tick apart
    clear_logs();
    strobe(9'd3, 9'd0);
    run(20);
    chk("x_pos_count", h_log.size(), 3);
    if (h_log.size() == 3) begin
      chk("x_pos_ph0", int'(h_log[0]), int'(2'b10));
      chk("x_pos_ph1", int'(h_log[1]), int'(2'b11));
      chk("x_pos_ph2", int'(h_log[2]), int'(2'b01));
      chk("x_pos_gap0", h_cyc[1] - h_cyc[0], SD);
      chk("x_pos_gap1", h_cyc[2] - h_cyc[1], SD);
    end
    chk("x_pos_v_static", v_log.size(), 0);
    chk("x_pos_busy", int'(busy), 0);

    // 3. Negative Y from phase 00
    clear_logs();
    strobe(9'd0, 9'h1FE);
    run(20);
    chk("y_neg_count", v_log.size(), 2);
    if (v_log.size() == 2) begin
      chk("y_neg_ph0", int'(v_log[0]), int'(2'b01));
      chk("y_neg_ph1", int'(v_log[1]), int'(2'b11));
    end
    chk("y_neg_h_static", h_log.size(), 0);
    chk("y_neg_busy", int'(busy), 0);

    // 4. Saturation: three strobes placed clear of any tick
    n = 0;
    while ((m_div != 0) && (n < SD + 1)) begin cycle(); n++; end
    p0 = m_posx;
    clear_logs();
    strobe(9'd255, 9'd0);
    strobe(9'd255, 9'd0);
    strobe(9'd255, 9'd0);
    drain();
    run(SD + 2);
    chk("sat_steps", h_log.size(), 511);
    chk("sat_final_ph", int'({tb1HC, tb1HD}), int'(ph_of(p0 + 511)));

    // 5. Strobe coincident with a tick while acc = +1
    n = 0;
    while ((m_div != SD - 2) && (n < SD + 1)) begin cycle(); n++; end
    p0 = m_posx;
    clear_logs();
    strobe(9'd1, 9'd0);
    strobe(9'h1FD, 9'd0);
    run(20);
    chk("coinc_count", h_log.size(), 4);
    if (h_log.size() == 4) begin
      chk("coinc_fwd", int'(h_log[0]), int'(ph_of(p0 + 1)));
      chk("coinc_back0", int'(h_log[1]), int'(ph_of(p0)));
      chk("coinc_back1", int'(h_log[2]), int'(ph_of(p0 - 1)));
      chk("coinc_back2", int'(h_log[3]), int'(ph_of(p0 - 2)));
    end

    // 6. Disable mid-operation, then asynchronous reset
    strobe(9'd100, 9'd0);
    run(10);
    enable = 1'b0;
    cycle();
    p0 = m_posx;
    clear_logs();
    run(20);
    chk("dis_busy", int'(busy), 0);
    enable = 1'b1;
    run(20);
    chk("dis_no_edges", h_log.size(), 0);
    chk("dis_phase_held", int'({tb1HC, tb1HD}), int'(ph_of(p0)));
    strobe(9'd50, 9'h1F0);
    run(6);
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk("async_reset", int'({tb1HC, tb1HD, tb1VC, tb1VD, busy}), 0);
    run(3);
    reset_n = 1'b1;
    run(8);

    // Randomized deltas with occasional disable windows
    for (int i = 0; i < 40; i++) begin
      strobe(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
      run($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 5));
        enable = 1'b1;
      end
    end
    drain();
    run(SD + 2);
    chk("final_idle", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
